// File: rtl/serial_adder_sched.sv
// serial_adder_sched: round-robin arbiter that shares one serial adder
// between NREQ requesters, drives its start handshake and times out on done.
module serial_adder_sched #(
    parameter int NREQ = 4,
    parameter int IW   = 2,
    parameter int TMO  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            adder_done,
    output logic            adder_start,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic [NREQ-1:0] ack,
    output logic            err,
    output logic            busy
);
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        IDLE, GRANT, START, WAIT_LO, WAIT_HI, ACK, ERR
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            win_vld;
    logic            tmo_hit;
    logic            start_d;
    logic            err_d;
    logic            busy_d;
    logic [NREQ-1:0] gnt_d;
    logic [NREQ-1:0] ack_d;
    logic [IW-1:0]   idx_d;

    // Scan starts just after the last served requester
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // >= so an exit to WAIT_HI on the last count still times out next cycle
    assign tmo_hit = (cnt >= CW'(TMO - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= IW'(NREQ - 1);
            cnt         <= '0;
            adder_start <= 1'b0;
            gnt         <= '0;
            gnt_idx     <= '0;
            ack         <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            adder_start <= start_d;
            gnt         <= gnt_d;
            gnt_idx     <= idx_d;
            ack         <= ack_d;
            err         <= err_d;
            busy        <= busy_d;
            if (state == ACK || state == ERR)
                ptr <= gnt_idx;
            if (state_nx == WAIT_LO && state != WAIT_LO)
                cnt <= '0;
            else if (state == WAIT_LO || state == WAIT_HI)
                cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (win_vld && adder_done) state_nx = GRANT;
            GRANT:   state_nx = START;
            START:   state_nx = WAIT_LO;
            WAIT_LO: begin
                if (!adder_done)  state_nx = WAIT_HI;
                else if (tmo_hit) state_nx = ERR;
            end
            WAIT_HI: begin
                if (adder_done)   state_nx = ACK;
                else if (tmo_hit) state_nx = ERR;
            end
            ACK:     state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered
    always_comb begin
        start_d = 1'b0;
        err_d   = 1'b0;
        ack_d   = '0;
        gnt_d   = gnt;
        idx_d   = gnt_idx;
        busy_d  = busy;
        unique case (state_nx)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
            GRANT: begin
                gnt_d  = NREQ'(1) << win_idx;
                idx_d  = win_idx;
                busy_d = 1'b1;
            end
            START:   start_d = 1'b1;
            ACK:     ack_d   = gnt;
            ERR:     err_d   = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: doc/serial_adder_sched.md
Name: serial_adder_sched

Overview:
Round-robin scheduler that shares one quad serial adder (adder controller plus shift-register datapath) between NREQ requesters. It arbitrates requests and grants one requester the operand/result mux. It drives the adder's start handshake (pulse high, then low) and tracks the adder's done signal through the busy window. It returns a one-cycle ack per completed operation and aborts with an error pulse if the adder never completes.

Parameters:
NREQ, 4, number of requesters (2..8)
IW, 2, width of grant index (clog2 NREQ)
TMO, 64, max cycles from start release to done re-assertion before timeout (>= adder bit count + 4)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (sampled on rising clk edge; rst=0 resets)
req  in  NREQ  per-requester operation request, level, held until ack/err
adder_done  in  1  done from adder controller (high when adder idle)
adder_start  out  1  start to adder controller
gnt  out  NREQ  one-hot grant, selects operand/result mux
gnt_idx  out  IW  binary index of granted requester (valid while busy=1)
ack  out  NREQ  one-cycle completion pulse to granted requester
err  out  1  one-cycle timeout pulse
busy  out  1  high from GRANT through ACK/ERR

Behaviour:
- Reset (rst=0 at clock edge): state=IDLE, adder_start=0, gnt=0, gnt_idx=0, ack=0, err=0, busy=0, timeout counter=0, rr pointer=NREQ-1, so req[0] has first priority. Reset mid-operation aborts immediately: no ack, no err.
- States: IDLE, GRANT, START, WAIT_LO, WAIT_HI, ACK, ERR. All outputs are registered.
- IDLE: if |req and adder_done=1, pick winner = first set req bit scanning ptr+1, ptr+2, ... (mod NREQ) -> GRANT. Otherwise stay. req with adder_done=0 waits.
- GRANT (1 cycle): gnt/gnt_idx load winner, busy=1. This gives the mux one cycle to settle before start -> START.
- START (1 cycle): adder_start=1 -> WAIT_LO. adder_start drops next cycle, which releases the adder's START->INIT transition.
- WAIT_LO: adder_start=0. Wait for adder_done=0 (adder left IDLE) -> WAIT_HI.
- WAIT_HI: wait for adder_done=1 -> ACK.
- Timeout counter clears on entry to WAIT_LO and increments each cycle in WAIT_LO/WAIT_HI. On reaching TMO-1 without the exit condition -> ERR.
- ACK (1 cycle): ack[gnt_idx]=1, ptr<=gnt_idx, gnt and busy clear on exit -> IDLE.
- ERR (1 cycle): err=1, ack=0, ptr<=gnt_idx (the failing requester loses priority), gnt and busy clear on exit -> IDLE.
- Minimum latency, req to ack: IDLE sample, GRANT, START, WAIT_LO (>=1), WAIT_HI (>=1), ACK. ack is asserted 5+ cycles after req is sampled.
- Grant is held for the whole transaction. A requester dropping req mid-transaction is ignored: the operation completes and ack still pulses. New requests arriving while busy queue until IDLE.
- Requester sees ack in cycle T and must drop req by T+1. IDLE is re-entered at T+1, so a req still high there is regranted.
- Simultaneous requests: exactly one gnt bit is ever set. Fairness: any continuously asserted req is granted within NREQ transactions.
- If done rises and timeout expires in the same cycle, done wins (ACK).
- adder_start is never asserted unless exactly one gnt bit is set.

Test Plan:
- Reset with req=4'b1111, rst=0 for 2 cycles -> all outputs 0. After release with adder_done=1, first grant is gnt=4'b0001, gnt_idx=0.
- Single req=4'b0100, adder model done low 17 cycles -> gnt=0100 from cycle 1, adder_start high exactly cycle 2, ack=0100 for one cycle after done rises, busy low next cycle.
- req=4'b1111 held, re-raised after each ack -> grant order 0,1,2,3,0. No cycle with two gnt bits set.
- adder model never drops done after start -> err pulses 1 cycle at TMO=64 cycles after WAIT_LO entry, ack stays 0, next grant skips the failed index.
- rst=0 asserted while in WAIT_HI -> next cycle gnt=0, busy=0, no ack/err pulse. Pending req is regranted from ptr reset (index 0 first).
- req[1] dropped during WAIT_HI -> ack[1] still pulses on done. adder_done=0 in IDLE with req pending -> no grant until done=1.
